seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
Parallel-to-serial front end for the overlapping sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clk on ser_out; ser_out connects directly to the detector's in port. A one-word holding buffer lets back-to-back words stream with no idle cycle between them.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
IDLE_BIT, 0, level driven on ser_out while no word is being shifted.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset.
load_data  input  WIDTH  word to serialize.
load_valid  input  1  load_data is valid this cycle.
load_ready  output  1  block can accept a word this cycle.
ser_out  output  1  serial bit stream to the detector.
ser_valid  output  1  ser_out carries a data bit (not idle fill).
last  output  1  ser_out carries the final bit of the current word.
busy  output  1  shifter active or holding buffer full.

Behaviour:
- Reset (rst low, async): state=IDLE, shift reg=0, cnt=0, hold_full=0.
  - Outputs during and after reset: ser_out=IDLE_BIT, ser_valid=0, last=0, busy=0, load_ready=1.
  - Asserting rst mid-word aborts the word at once, discards the hold buffer and truncates the stream. There is no flush.
- Storage: shift reg sh[WIDTH]; bit counter cnt, width clog2(WIDTH); hold[WIDTH]; hold_full.
- Handshake:
  - Accept = load_valid && load_ready, sampled at posedge.
  - load_ready = !hold_full (combinational from a register).
  - load_data is ignored when load_valid=0.
- FSM states:
  - IDLE: ser_valid=0, ser_out=IDLE_BIT. On accept, load sh from load_data, cnt=0, go to SHIFT.
    - First bit appears on ser_out in the cycle after the accepting edge (latency 1).
  - SHIFT: ser_out = sh[WIDTH-1] if MSB_FIRST, else sh[0]; ser_valid=1.
    - While cnt < WIDTH-1: shift each clk, cnt++. Accepts in this state write hold and set hold_full.
    - When cnt==WIDTH-1 (last=1), at the next edge, in priority order:
      - (a) hold_full: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT.
      - (b) else accept this cycle: sh<=load_data (bypass), cnt<=0, stay in SHIFT.
      - (c) else go to IDLE.
    - Cases (a) and (b) give gapless streaming: bit WIDTH-1 of word k is followed directly by bit 0 of word k+1.
- Outputs:
  - ser_out, ser_valid and last are functions of registered state only (Moore). No in-to-out combinational path except load_ready.
  - last = (state==SHIFT) && (cnt==WIDTH-1).
  - busy = (state==SHIFT) || hold_full.
- Simultaneous events:
  - At the last bit with hold_full=1, load_ready=0, so no accept occurs. hold drains to sh and load_ready returns to 1 in the next cycle.
  - An accept in a non-last SHIFT cycle while hold is empty fills hold. The next word is then queued, and a third word stalls.
- Sustained throughput: one word per WIDTH cycles, zero bubbles.

Decomposition:
- Shared package: state encodings (S_IDLE=1'b0, S_SHIFT=1'b1) and the default WIDTH constant, reused by the detector testbenches.
- Single module. The hold buffer is too small to justify a sub-module.

Test Plan:
- Reset: hold rst low for 3 clk with load_valid=1 -> ser_valid=0, ser_out=IDLE_BIT, load_ready=1, no word accepted.
- Single word: WIDTH=8, MSB_FIRST=1, load 8'b11011011 -> ser_out reads 1,1,0,1,1,0,1,1 in cycles 1..8 after the accept; last=1 only in cycle 8; IDLE in cycle 9. A downstream 11011 overlapping detector asserts out after bits 5 and 8.
- Gapless stream: load 8'hDB then 8'h6C (second word presented in cycle 2) -> 16 consecutive ser_valid cycles with no gap; load_ready=0 from cycle 3 until the hold buffer drains at the word boundary.
- Backpressure: hold load_valid high with three words -> third word stalls (load_ready=0) until the word-1/word-2 boundary; all three words emitted in order, none lost or duplicated.
- Bit order: MSB_FIRST=0, load 8'b00011011 -> ser_out reads 1,1,0,1,1,0,0,0.
- Mid-word reset: drop rst during bit 4 with hold_full=1 -> ser_valid=0 immediately (async); after release load_ready=1, busy=0, and the held word is never emitted.

Source files
------------

// File: rtl/seq_bit_serializer_pkg.sv
// ----------------------------------------------------------------------------
// seq_bit_serializer_pkg
// Shared definitions for the parallel-to-serial front end of the overlapping
// sequence detectors. The detector testbenches import the same package, so
// they use the same state encodings and default word width.
//
// Contents:
//   state_e        - serializer FSM state encoding (IDLE / SHIFT)
//   DEFAULT_WIDTH  - default number of bits per word
//   MIN_WIDTH,
//   MAX_WIDTH      - legal range of the WIDTH parameter
// ----------------------------------------------------------------------------
package seq_bit_serializer_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_e;

   localparam int DEFAULT_WIDTH = 8;
   localparam int MIN_WIDTH     = 2;
   localparam int MAX_WIDTH     = 32;

endpackage : seq_bit_serializer_pkg

// File: rtl/seq_bit_serializer.sv
// ----------------------------------------------------------------------------
// seq_bit_serializer
// Takes WIDTH-bit words over a valid/ready handshake and emits one bit per
// clock on ser_out. A one-word holding buffer queues the next word while the
// current word shifts out. Consecutive words therefore stream with no idle
// cycle between them.
//
// Parameters:
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   IDLE_BIT   level on ser_out while no word is shifting
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous reset, active low
//   load_data   in   word to serialize
//   load_valid  in   load_data valid this cycle
//   load_ready  out  a word can be accepted this cycle
//   ser_out     out  serial bit stream to the detector
//   ser_valid   out  ser_out carries a data bit
//   last        out  ser_out carries the final bit of the current word
//   busy        out  shifter active or holding buffer full
// ----------------------------------------------------------------------------
module seq_bit_serializer
   import seq_bit_serializer_pkg::*;
#(
   parameter int   WIDTH     = DEFAULT_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             last,
   output logic             busy
);

   localparam int                 CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_full_q, hold_full_d;

   logic               accept;
   logic               at_last;
   logic [WIDTH-1:0]   sh_shifted;

   // -------------------------------------------------------------------------
   // Handshake and status
   // -------------------------------------------------------------------------
   // load_ready depends on a register only. No combinational path runs from
   // load_valid to load_ready, so an upstream source can safely wait on it.
   assign load_ready = !hold_full_q;
   assign accept     = load_valid && load_ready;
   assign at_last    = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);

   // The head bit always sits at the output end of the register. Each shift
   // moves the next bit toward that end.
   assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, sh_q[WIDTH-1:1]};

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case statement. A branch
      // that leaves a signal unassigned therefore holds the register value
      // and does not infer a latch.
      state_d     = state_q;
      sh_d        = sh_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               sh_d    = load_data;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (!at_last) begin
               sh_d  = sh_shifted;
               cnt_d = cnt_q + CNT_W'(1);
               if (accept) begin
                  hold_d      = load_data;
                  hold_full_d = 1'b1;
               end
            end else if (hold_full_q) begin
               // The queued word follows the final bit directly. load_ready is
               // low in this cycle, so no new word can compete for the shifter.
               sh_d        = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
            end else if (accept) begin
               // The hold buffer is empty. The new word bypasses it and goes
               // straight into the shifter, which keeps the stream gapless.
               sh_d  = load_data;
               cnt_d = '0;
            end else begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. All registers
   // then update together at the edge, whatever order the processes run in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         sh_q        <= '0;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
      end
   end

   // NOTE: the hold data register has no reset. hold_full_q qualifies it, and
   // its contents are never observed while that flag is clear.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   // -------------------------------------------------------------------------
   // Moore outputs
   // -------------------------------------------------------------------------
   always_comb begin
      ser_out   = IDLE_BIT;
      ser_valid = 1'b0;
      if (state_q == S_SHIFT) begin
         ser_out   = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
         ser_valid = 1'b1;
      end
   end

   assign last = at_last;
   assign busy = (state_q == S_SHIFT) || hold_full_q;

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// ----------------------------------------------------------------------------
// tb_seq_bit_serializer
// Directed bench for seq_bit_serializer. It instantiates an MSB-first copy
// (the main DUT) and an LSB-first copy, which share clock and reset. Expected
// bits come from hand-picked words and known cycle positions.
// ----------------------------------------------------------------------------
module tb_seq_bit_serializer;
   import seq_bit_serializer_pkg::*;

   localparam int W = DEFAULT_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  load_data;
   logic          load_valid;
   logic          load_ready, ser_out, ser_valid, last, busy;
   logic [W-1:0]  lsb_data;
   logic          lsb_valid;
   logic          lsb_ready, lsb_out, lsb_ser_valid, lsb_last, lsb_busy;

   int            n_checks = 0;
   int            n_fail   = 0;

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .last       (last),
      .busy       (busy)
   );

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk        (clk),
      .rst        (rst),
      .load_data  (lsb_data),
      .load_valid (lsb_valid),
      .load_ready (lsb_ready),
      .ser_out    (lsb_out),
      .ser_valid  (lsb_ser_valid),
      .last       (lsb_last),
      .busy       (lsb_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      check(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   // Move to 1 time unit after the next rising edge. Outputs are stable then,
   // and the new inputs are driven for the following edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_bit({tag, " ser_valid"},  ser_valid,  1'b0);
      check_bit({tag, " ser_out"},    ser_out,    1'b0);
      check_bit({tag, " last"},       last,       1'b0);
      check_bit({tag, " busy"},       busy,       1'b0);
      check_bit({tag, " load_ready"}, load_ready, 1'b1);
   endtask

   // Bit of word w that appears in position idx (0 = first out).
   function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb);
      return msb ? w[W-1-idx] : w[idx];
   endfunction

   initial begin
      logic [W-1:0] words [3];
      logic [4:0]   hist;
      logic [W-1:0] w;
      logic         exp_v, exp_o, acc;
      int           nxt;
      int           n_valid;

      // ---------------- reset with load_valid asserted ----------------
      rst        = 1'b0;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      lsb_valid  = 1'b1;
      lsb_data   = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle($sformatf("reset c%0d", i));
         check_bit($sformatf("reset lsb c%0d ser_valid", i), lsb_ser_valid, 1'b0);
      end
      load_valid = 1'b0;
      lsb_valid  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step();
      check_idle("post-reset");
      check_bit("post-reset lsb busy", lsb_busy, 1'b0);

      // ---------------- single word, MSB first ----------------
      w          = 8'hDB;
      hist       = '0;
      load_data  = w;
      load_valid = 1'b1;
      check_bit("single ready", load_ready, 1'b1);
      step();
      load_valid = 1'b0;
      load_data  = '0;
      for (int c = 1; c <= 8; c++) begin
         check_bit($sformatf("single c%0d ser_valid", c), ser_valid, 1'b1);
         check_bit($sformatf("single c%0d ser_out", c), ser_out, exp_bit(w, c - 1, 1'b1));
         check_bit($sformatf("single c%0d last", c), last, (c == 8));
         check_bit($sformatf("single c%0d busy", c), busy, 1'b1);
         hist = {hist[3:0], ser_out};
         check_bit($sformatf("single c%0d det11011", c), (hist == 5'b11011), (c == 5 || c == 8));
         step();
      end
      check_idle("single c9");

      // ---------------- gapless stream via hold buffer ----------------
      load_data  = 8'hDB;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         w = (c <= 8) ? 8'hDB : 8'h6C;
         check_bit($sformatf("gap c%0d ser_valid", c), ser_valid, 1'b1);
         check_bit($sformatf("gap c%0d ser_out", c), ser_out, exp_bit(w, (c - 1) % 8, 1'b1));
         check_bit($sformatf("gap c%0d last", c), last, (c == 8 || c == 16));
         check_bit($sformatf("gap c%0d load_ready", c), load_ready, !(c >= 3 && c <= 8));
         load_valid = (c == 2);
         load_data  = (c == 2) ? 8'h6C : 8'h00;
         step();
      end
      load_valid = 1'b0;
      check_idle("gap c17");

      // ---------------- bypass: next word offered on the last bit ----------------
      load_data  = 8'h96;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         w = (c <= 8) ? 8'h96 : 8'h2D;
         check_bit($sformatf("byp c%0d ser_valid", c), ser_valid, 1'b1);
         check_bit($sformatf("byp c%0d ser_out", c), ser_out, exp_bit(w, (c - 1) % 8, 1'b1));
         check_bit($sformatf("byp c%0d last", c), last, (c == 8 || c == 16));
         check_bit($sformatf("byp c%0d load_ready", c), load_ready, 1'b1);
         load_valid = (c == 8);
         load_data  = (c == 8) ? 8'h2D : 8'h00;
         step();
      end
      load_valid = 1'b0;
      check_idle("byp c17");

      // ---------------- backpressure: three words, valid held high ----------------
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      words[2] = 8'hF0;
      nxt      = 0;
      n_valid  = 0;
      for (int c = 0; c <= 25; c++) begin
         exp_v = (c >= 1 && c <= 24);
         exp_o = exp_v ? exp_bit(words[exp_v ? (c - 1) / 8 : 0], (c - 1) % 8, 1'b1) : 1'b0;
         check_bit($sformatf("bp c%0d ser_valid", c), ser_valid, exp_v);
         check_bit($sformatf("bp c%0d ser_out", c), ser_out, exp_o);
         check_bit($sformatf("bp c%0d last", c), last, (c == 8 || c == 16 || c == 24));
         check_bit($sformatf("bp c%0d load_ready", c), load_ready,
                   !((c >= 2 && c <= 8) || (c >= 10 && c <= 16)));
         if (ser_valid) n_valid++;
         load_valid = (nxt < 3);
         load_data  = (nxt < 3) ? words[nxt] : 8'h00;
         acc        = load_valid && load_ready;
         step();
         if (acc) nxt++;
      end
      load_valid = 1'b0;
      check("bp words accepted", 32'(nxt), 32'd3);
      check("bp valid bit count", 32'(n_valid), 32'd24);
      check_idle("bp end");

      // ---------------- bit order, LSB first ----------------
      w         = 8'b0001_1011;
      lsb_data  = w;
      lsb_valid = 1'b1;
      step();
      lsb_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         check_bit($sformatf("lsb c%0d ser_valid", c), lsb_ser_valid, 1'b1);
         check_bit($sformatf("lsb c%0d ser_out", c), lsb_out, exp_bit(w, c - 1, 1'b0));
         check_bit($sformatf("lsb c%0d last", c), lsb_last, (c == 8));
         step();
      end
      check_bit("lsb c9 ser_valid", lsb_ser_valid, 1'b0);
      check_bit("lsb c9 busy", lsb_busy, 1'b0);

      // ---------------- mid-word reset with hold buffer full ----------------
      load_data  = 8'hDB;
      load_valid = 1'b1;
      step();                          // cycle 1
      load_data  = 8'h6C;              // goes into the hold buffer
      step();                          // cycle 2
      load_valid = 1'b0;
      step();                          // cycle 3
      step();                          // cycle 4
      check_bit("mrst pre busy", busy, 1'b1);
      check_bit("mrst pre load_ready", load_ready, 1'b0);
      check_bit("mrst pre ser_valid", ser_valid, 1'b1);
      #2 rst = 1'b0;
      #1;
      check_bit("mrst async ser_valid", ser_valid, 1'b0);
      check_bit("mrst async busy", busy, 1'b0);
      check_bit("mrst async load_ready", load_ready, 1'b1);
      check_bit("mrst async last", last, 1'b0);
      step();
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         check_bit($sformatf("mrst post c%0d ser_valid", c), ser_valid, 1'b0);
         check_bit($sformatf("mrst post c%0d busy", c), busy, 1'b0);
      end
      check_bit("mrst post load_ready", load_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_seq_bit_serializer
